// File: rtl/femto_pkg.sv
// Shared definitions for the femtoRV32 data path: load encodings, load-unit
// state type and access-size helpers.
package femto_pkg;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Access sizes in bytes
  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StRd0,
    StRd1,
    StResp
  } ld_state_t;

  function automatic logic f3_legal(logic [2:0] f3);
    logic ok;
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Size follows funct3[1:0]; only meaningful for legal encodings
  function automatic logic [2:0] ld_size(logic [2:0] f3);
    logic [2:0] sz;
    case (f3[1:0])
      2'b00:   sz = SZ_B;
      2'b01:   sz = SZ_H;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

  // Access spills into the next word when offset + size exceeds 4 bytes
  function automatic logic ld_split(logic [1:0] offset, logic [2:0] f3);
    return ({1'b0, offset} + ld_size(f3)) > 3'd4;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load alignment and extension: picks the addressed bytes out
// of a two-word window and sign/zero-extends them according to funct3.
module load_extend
  import femto_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] data,
  input  logic [1:0]        offset,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] shifted;

  // Shift the addressed byte down to bit 0, then extend by load type
  always_comb begin
    shifted = data >> {offset, 3'b000};
    result  = '0;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   result = shifted[XLEN-1:0];
      F3_LBU:  result = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_load_unit.sv
// Multi-cycle RV32I load unit. Reads one or two words from a word-addressed
// data memory and returns the extended load result as a one-cycle pulse.
module dmem_load_unit
  import femto_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic [2:0]      req_funct3,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  ld_state_t       state_q;
  logic [AW-1:0]   addr_q;
  logic [2:0]      funct3_q;
  logic            err_q;
  logic [XLEN-1:0] buf0_q;
  logic [XLEN-1:0] buf1_q;

  logic [AW-1:0]   word_addr;
  logic [XLEN-1:0] ext_data;

  assign word_addr = {addr_q[AW-1:2], 2'b00};

  load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .data  ({buf1_q, buf0_q}),
    .offset(addr_q[1:0]),
    .funct3(funct3_q),
    .result(ext_data)
  );

  // Load FSM with request latches and read buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      funct3_q <= '0;
      err_q    <= 1'b0;
      buf0_q   <= '0;
      buf1_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            err_q    <= !f3_legal(req_funct3);
            state_q  <= f3_legal(req_funct3) ? StRd0 : StResp;
          end
        end
        StRd0: begin
          if (mem_ack) begin
            buf0_q  <= mem_rdata;
            state_q <= ld_split(addr_q[1:0], funct3_q) ? StRd1 : StResp;
          end
        end
        StRd1: begin
          if (mem_ack) begin
            buf1_q  <= mem_rdata;
            state_q <= StResp;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decoded from registered state only; second read wraps mod 2^AW
  always_comb begin
    req_ready = (state_q == StIdle);
    mem_req   = (state_q == StRd0) || (state_q == StRd1);
    mem_addr  = '0;
    if (state_q == StRd0) begin
      mem_addr = word_addr;
    end else if (state_q == StRd1) begin
      mem_addr = word_addr + AW'(4);
    end
    rsp_valid = (state_q == StResp);
    rsp_err   = (state_q == StResp) && err_q;
    rsp_data  = ((state_q == StResp) && !err_q) ? ext_data : '0;
  end

endmodule

// File: tb/tb_dmem_load_unit.sv
// Directed bench for dmem_load_unit with a behavioural word memory.
module tb_dmem_load_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  dmem_load_unit #(
    .XLEN(32),
    .AW  (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_funct3(req_funct3),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Memory model and bus monitor state
  logic [31:0] mem_words [logic [31:0]];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          ack_hold = 0;
  bit          stray_ack = 0;
  logic [31:0] hs_q[$];
  int          req_cycles = 0;
  int          unstable = 0;
  bit          pend = 0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // Responder: ack after ack_delay wait cycles, or drive a stray ack when held
  always @(negedge clk) begin
    if (ack_hold) begin
      mem_ack   = stray_ack;
      mem_rdata = 32'hA5A5A5A5;
      wait_cnt  = 0;
    end else if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_rd(mem_addr);
        wait_cnt  = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  // Monitor: log completed reads and catch address changes while waiting
  always @(posedge clk) begin
    if (mem_req) begin
      req_cycles = req_cycles + 1;
      if (pend && mem_addr != pend_addr) unstable = unstable + 1;
      if (mem_ack) begin
        hs_q.push_back(mem_addr);
        pend = 0;
      end else begin
        pend      = 1;
        pend_addr = mem_addr;
      end
    end else begin
      pend = 0;
    end
  end

  task automatic run_load(input string name, input logic [31:0] addr, input logic [2:0] f3,
                          output logic [31:0] data, output logic err, output int lat);
    hs_q.delete();
    req_cycles = 0;
    unstable   = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_funct3 = f3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    data = rsp_data;
    err  = rsp_err;
    if (!rsp_valid) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got no rsp_valid want rsp_valid within 60 cycles", name);
    end
    @(negedge clk);
    check({name, " pulse"}, {31'b0, rsp_valid}, 32'd0);
    check({name, " ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_nreq;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int          nrsp;

    vecs[0]  = '{"lw_aligned",  32'h100, 3'b010, 32'hDEADBEEF, 32'h0, 32'h100, 32'h104,
                 32'hDEADBEEF, 1'b0, 2, 1};
    vecs[1]  = '{"lb_neg",      32'h103, 3'b000, 32'h80FF0000, 32'h0, 32'h100, 32'h104,
                 32'hFFFFFF80, 1'b0, 2, 1};
    vecs[2]  = '{"lbu",         32'h103, 3'b100, 32'h80FF0000, 32'h0, 32'h100, 32'h104,
                 32'h00000080, 1'b0, 2, 1};
    vecs[3]  = '{"lh_neg",      32'h102, 3'b001, 32'h80FF0000, 32'h0, 32'h100, 32'h104,
                 32'hFFFF80FF, 1'b0, 2, 1};
    vecs[4]  = '{"lhu",         32'h102, 3'b101, 32'h80FF0000, 32'h0, 32'h100, 32'h104,
                 32'h000080FF, 1'b0, 2, 1};
    vecs[5]  = '{"lb_pos",      32'h101, 3'b000, 32'h00007F00, 32'h0, 32'h100, 32'h104,
                 32'h0000007F, 1'b0, 2, 1};
    vecs[6]  = '{"lh_pos_off2", 32'h202, 3'b001, 32'h1234ABCD, 32'h0, 32'h200, 32'h204,
                 32'h00001234, 1'b0, 2, 1};
    vecs[7]  = '{"lh_split",    32'h203, 3'b001, 32'hAB000000, 32'h000000CD, 32'h200, 32'h204,
                 32'hFFFFCDAB, 1'b0, 3, 2};
    vecs[8]  = '{"lhu_split",   32'h203, 3'b101, 32'hAB000000, 32'h000000CD, 32'h200, 32'h204,
                 32'h0000CDAB, 1'b0, 3, 2};
    vecs[9]  = '{"lw_split",    32'h201, 3'b010, 32'h44332211, 32'h88776655, 32'h200, 32'h204,
                 32'h55443322, 1'b0, 3, 2};
    vecs[10] = '{"lw_wrap",     32'hFFFFFFFE, 3'b010, 32'h12340000, 32'h00005678,
                 32'hFFFFFFFC, 32'h0, 32'h56781234, 1'b0, 3, 2};
    vecs[11] = '{"illegal_011", 32'h100, 3'b011, 32'h11111111, 32'h0, 32'h0, 32'h0,
                 32'h0, 1'b1, 1, 0};
    vecs[12] = '{"illegal_111", 32'h100, 3'b111, 32'h11111111, 32'h0, 32'h0, 32'h0,
                 32'h0, 1'b1, 1, 0};

    // Reset state
    #1;
    check("rst req_ready", {31'b0, req_ready}, 32'd1);
    check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst rsp_data", rsp_data, 32'd0);
    check("rst mem_req", {31'b0, mem_req}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait table
    for (int i = 0; i < 13; i++) begin
      mem_words.delete();
      mem_words[vecs[i].a0] = vecs[i].w0;
      mem_words[vecs[i].a1] = vecs[i].w1;
      run_load(vecs[i].name, vecs[i].addr, vecs[i].f3, d, e, lat);
      check({vecs[i].name, " data"}, d, vecs[i].exp_data);
      check({vecs[i].name, " err"}, {31'b0, e}, {31'b0, vecs[i].exp_err});
      check({vecs[i].name, " latency"}, lat, vecs[i].exp_lat);
      check({vecs[i].name, " nreq"}, hs_q.size(), vecs[i].exp_nreq);
      check({vecs[i].name, " req_cycles"}, req_cycles, vecs[i].exp_nreq);
      if (vecs[i].exp_nreq >= 1 && hs_q.size() >= 1)
        check({vecs[i].name, " addr0"}, hs_q[0], vecs[i].a0);
      if (vecs[i].exp_nreq >= 2 && hs_q.size() >= 2)
        check({vecs[i].name, " addr1"}, hs_q[1], vecs[i].a1);
    end

    // Split LH with three wait cycles per read
    mem_words.delete();
    mem_words[32'h200] = 32'hAB000000;
    mem_words[32'h204] = 32'h000000CD;
    ack_delay = 3;
    run_load("lh_wait", 32'h203, 3'b001, d, e, lat);
    ack_delay = 0;
    check("lh_wait data", d, 32'hFFFFCDAB);
    check("lh_wait err", {31'b0, e}, 32'd0);
    check("lh_wait latency", lat, 9);
    check("lh_wait nreq", hs_q.size(), 2);
    check("lh_wait req_cycles", req_cycles, 8);
    check("lh_wait unstable", unstable, 0);
    if (hs_q.size() == 2) begin
      check("lh_wait addr0", hs_q[0], 32'h200);
      check("lh_wait addr1", hs_q[1], 32'h204);
    end

    // Reset while RD0 is waiting, then a stray late ack
    ack_hold  = 1;
    stray_ack = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = 32'h300;
    req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rd0 mem_req", {31'b0, mem_req}, 32'd1);
    check("rd0 mem_addr", mem_addr, 32'h300);
    #2 rst_n = 1'b0;
    #1;
    check("rst async mem_req", {31'b0, mem_req}, 32'd0);
    check("rst async req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray_ack = 1;
    @(negedge clk);
    stray_ack = 0;
    nrsp = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    check("post_rst rsp count", nrsp, 0);
    check("post_rst req_ready", {31'b0, req_ready}, 32'd1);
    check("post_rst mem_req", {31'b0, mem_req}, 32'd0);
    ack_hold = 0;

    mem_words.delete();
    mem_words[32'h100] = 32'hCAFEF00D;
    run_load("lw_after_rst", 32'h100, 3'b010, d, e, lat);
    check("lw_after_rst data", d, 32'hCAFEF00D);
    check("lw_after_rst err", {31'b0, e}, 32'd0);
    check("lw_after_rst latency", lat, 2);
    check("lw_after_rst nreq", hs_q.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
